// File: rtl/cache_ctrl_assoc.sv
// Write-back, write-allocate cache controller, 1 or 2 ways with LRU.
// Tag/valid/dirty/data storage is internal; four-state FSM.
module cache_ctrl_assoc #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int INDEX_W = 10,
  parameter int WAYS    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [31:0]       cpu_req_data,
  input  logic              cpu_req_rw,
  input  logic              cpu_req_valid,
  output logic [31:0]       cpu_res_data,
  output logic              cpu_res_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  output logic              mem_req_rw,
  output logic              mem_req_valid,
  input  logic [LINE_W-1:0] mem_data,
  input  logic              mem_ready
);

  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS     = 1 << INDEX_W;
  localparam int WORD_W   = OFFSET_W - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITE_BACK,
    S_ALLOCATE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:2]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                rw_q, rw_d;
  logic                victim_q, victim_d;

  logic [SETS-1:0]     valid_q [2];
  logic [SETS-1:0]     dirty_q [2];
  logic [SETS-1:0]     lru_q;
  logic [TAG_W-1:0]    tag_q   [2][SETS];
  logic [LINE_W-1:0]   data_q  [2][SETS];

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  idx;
  logic [WORD_W+4:0]   woff;
  logic                hit0, hit1, hit, hit_way;
  logic                victim_sel;
  logic [LINE_W-1:0]   hit_line;
  logic                wr_hit, lru_upd, fill;
  logic                unused_addr;

  assign unused_addr = ^cpu_req_addr[1:0];

  always_comb begin
    req_tag  = addr_q[ADDR_W-1 -: TAG_W];
    idx      = addr_q[OFFSET_W +: INDEX_W];
    woff     = {addr_q[OFFSET_W-1:2], 5'b00000};
    hit0     = valid_q[0][idx] && (tag_q[0][idx] == req_tag);
    hit1     = (WAYS == 2) && valid_q[1][idx] &&
               (tag_q[1][idx] == req_tag);
    hit      = hit0 || hit1;
    hit_way  = !hit0;
    hit_line = hit_way ? data_q[1][idx] : data_q[0][idx];
    // Prefer an empty way; otherwise evict the LRU way
    if (WAYS != 2)            victim_sel = 1'b0;
    else if (!valid_q[0][idx]) victim_sel = 1'b0;
    else if (!valid_q[1][idx]) victim_sel = 1'b1;
    else                       victim_sel = lru_q[idx];
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rw_d          = rw_q;
    victim_d      = victim_q;
    cpu_res_data  = '0;
    cpu_res_ready = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_rw    = 1'b0;
    mem_req_valid = 1'b0;
    wr_hit        = 1'b0;
    lru_upd       = 1'b0;
    fill          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req_valid) begin
          addr_d  = cpu_req_addr[ADDR_W-1:2];
          wdata_d = cpu_req_data;
          rw_d    = cpu_req_rw;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          cpu_res_ready = 1'b1;
          if (!rw_q) cpu_res_data = hit_line[woff +: 32];
          wr_hit  = rw_q;
          lru_upd = 1'b1;
          state_d = S_IDLE;
        end else begin
          victim_d = victim_sel;
          if (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx])
            state_d = S_WRITE_BACK;
          else
            state_d = S_ALLOCATE;
        end
      end
      S_WRITE_BACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {tag_q[victim_q][idx], idx, {OFFSET_W{1'b0}}};
        mem_req_data  = data_q[victim_q][idx];
        if (mem_ready) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        if (mem_ready) begin
          fill    = 1'b1;
          state_d = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      victim_q   <= 1'b0;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      victim_q <= victim_d;
      if (wr_hit) dirty_q[hit_way][idx] <= 1'b1;
      if (fill) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
      if (lru_upd && WAYS == 2) lru_q[idx] <= !hit_way;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_hit) data_q[hit_way][idx][woff +: 32] <= wdata_q;
    if (fill) begin
      data_q[victim_q][idx] <= mem_data;
      tag_q[victim_q][idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Directed bench: a 2-way and a 1-way cache sharing one memory responder.
// Expected values are hand-computed from the line pattern below.
module tb_cache_ctrl_assoc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sel = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_data = '0;
  logic         req_rw = 1'b0;
  logic         req_valid = 1'b0;
  logic [127:0] mem_data = '0;
  logic         mem_ready = 1'b0;

  logic [31:0]  rd0, rd1, ma0, ma1;
  logic [127:0] md0, md1;
  logic         rr0, rr1, mrw0, mrw1, mv0, mv1;

  logic [31:0]  res_data, m_addr;
  logic [127:0] m_data;
  logic         res_ready, m_rw, m_valid;

  int n_chk = 0;
  int n_pass = 0;
  int res_cyc, wb_cyc, al_cyc, n_wb, n_al;
  logic [31:0]  got_data, wb_addr, al_addr;
  logic [127:0] wb_data;

  always #5 clk = ~clk;

  cache_ctrl_assoc #(.WAYS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_addr(req_addr), .cpu_req_data(req_data),
    .cpu_req_rw(req_rw), .cpu_req_valid(req_valid && !sel),
    .cpu_res_data(rd0), .cpu_res_ready(rr0),
    .mem_req_addr(ma0), .mem_req_data(md0),
    .mem_req_rw(mrw0), .mem_req_valid(mv0),
    .mem_data(mem_data), .mem_ready(mem_ready && !sel)
  );

  cache_ctrl_assoc #(.WAYS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_addr(req_addr), .cpu_req_data(req_data),
    .cpu_req_rw(req_rw), .cpu_req_valid(req_valid && sel),
    .cpu_res_data(rd1), .cpu_res_ready(rr1),
    .mem_req_addr(ma1), .mem_req_data(md1),
    .mem_req_rw(mrw1), .mem_req_valid(mv1),
    .mem_data(mem_data), .mem_ready(mem_ready && sel)
  );

  always_comb begin
    res_data  = sel ? rd1  : rd0;
    res_ready = sel ? rr1  : rr0;
    m_addr    = sel ? ma1  : ma0;
    m_data    = sel ? md1  : md0;
    m_rw      = sel ? mrw1 : mrw0;
    m_valid   = sel ? mv1  : mv0;
  end

  function automatic logic [127:0] line_pat(input logic [31:0] a);
    return {a ^ 32'h3333_0000, a ^ 32'h2222_0000,
            a ^ 32'hDEAD_AEEF, a ^ 32'h1111_0000};
  endfunction

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  // Issue one request at a negedge; memory answers in the first cycle.
  task automatic access(input logic rw, input logic [31:0] a,
                        input logic [31:0] d);
    res_cyc = -1; wb_cyc = -1; al_cyc = -1;
    n_wb = 0; n_al = 0;
    got_data = '0; wb_addr = '0; al_addr = '0; wb_data = '0;
    req_addr = a; req_rw = rw; req_data = d; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (m_valid) begin
        mem_data  = line_pat(m_addr);
        mem_ready = 1'b1;
        if (m_rw) begin
          n_wb++; wb_addr = m_addr; wb_data = m_data; wb_cyc = c;
        end else begin
          n_al++; al_addr = m_addr; al_cyc = c;
        end
      end else begin
        mem_ready = 1'b0;
      end
      if (res_ready) begin
        res_cyc = c; got_data = res_data;
        break;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset ctl", {res_ready, m_valid, m_rw}, 3'b000);
    check("reset addr/data", {res_data, m_addr}, 64'h0);
    check("reset line", m_data, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    access(1'b0, 32'h0000_1004, 32'h0);
    check("cold alloc addr", al_addr, 32'h0000_1000);
    check("cold alloc cyc", al_cyc, 2);
    check("cold no wb", n_wb, 0);
    check("cold resp cyc", res_cyc, 3);
    check("cold data", got_data, 32'hDEADBEEF);

    access(1'b1, 32'h0000_1008, 32'h1234_5678);
    check("wr hit cyc", res_cyc, 1);
    check("wr hit no mem", n_wb + n_al, 0);
    access(1'b0, 32'h0000_1008, 32'h0);
    check("rd after wr cyc", res_cyc, 1);
    check("rd after wr data", got_data, 32'h1234_5678);

    access(1'b0, 32'h0000_1000, 32'h0);
    check("lru a hit", {res_cyc[7:0], 8'(n_al)}, {8'd1, 8'd0});
    check("lru a data", got_data, 32'h1111_1000);
    access(1'b0, 32'h0000_5000, 32'h0);
    check("lru b miss", {res_cyc[7:0], 8'(n_al), 8'(n_wb)},
          {8'd3, 8'd1, 8'd0});
    check("lru b data", got_data, 32'h1111_5000);
    access(1'b0, 32'h0000_1000, 32'h0);
    check("lru a rehit", res_cyc, 1);
    access(1'b0, 32'h0000_9000, 32'h0);
    check("lru c miss", {res_cyc[7:0], 8'(n_al), 8'(n_wb)},
          {8'd3, 8'd1, 8'd0});
    check("lru c data", got_data, 32'h1111_9000);
    access(1'b0, 32'h0000_1000, 32'h0);
    check("lru a kept", res_cyc, 1);
    access(1'b0, 32'h0000_5000, 32'h0);
    check("lru b evicted", {res_cyc[7:0], 8'(n_al)}, {8'd3, 8'd1});

    access(1'b1, 32'h0000_1000, 32'hA5A5_A5A5);
    check("dirty wr hit", res_cyc, 1);
    access(1'b0, 32'h0000_5000, 32'h0);
    check("dirty b hit", res_cyc, 1);
    access(1'b0, 32'h0000_9000, 32'h0);
    check("wb count", {8'(n_wb), 8'(n_al)}, {8'd1, 8'd1});
    check("wb addr", wb_addr, 32'h0000_1000);
    check("wb line", wb_data,
          {32'h3333_1000, 32'h1234_5678, 32'hDEADBEEF, 32'hA5A5_A5A5});
    check("wb then alloc", {8'(wb_cyc), 8'(al_cyc)}, {8'd2, 8'd3});
    check("evict alloc addr", al_addr, 32'h0000_9000);
    check("evict resp cyc", res_cyc, 4);
    check("evict data", got_data, 32'h1111_9000);

    req_addr = 32'h0000_1000; req_rw = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall hold", {m_valid, m_rw, res_ready, m_addr},
            {1'b1, 1'b0, 1'b0, 32'h0000_1000});
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst ctl", {res_ready, m_valid, m_rw}, 3'b000);
    check("rst addr/data", {res_data, m_addr}, 64'h0);
    check("rst line", m_data, 128'h0);
    rst_n = 1'b1;
    access(1'b0, 32'h0000_1000, 32'h0);
    check("post rst miss", {res_cyc[7:0], 8'(n_al)}, {8'd3, 8'd1});
    check("post rst data", got_data, 32'h1111_1000);

    sel = 1'b1;
    @(negedge clk);
    access(1'b0, 32'h0000_1000, 32'h0);
    check("w1 a miss", {res_cyc[7:0], 8'(n_al)}, {8'd3, 8'd1});
    check("w1 a addr", al_addr, 32'h0000_1000);
    access(1'b0, 32'h0000_5000, 32'h0);
    check("w1 b miss", {res_cyc[7:0], 8'(n_al)}, {8'd3, 8'd1});
    check("w1 b data", got_data, 32'h1111_5000);
    access(1'b0, 32'h0000_1000, 32'h0);
    check("w1 a remiss", {res_cyc[7:0], 8'(n_al), 8'(n_wb)},
          {8'd3, 8'd1, 8'd0});
    check("w1 a data", got_data, 32'h1111_1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_assoc.md
# cache_ctrl_assoc

Parametrised write-back, write-allocate cache controller between the CPU request port and the line-wide memory port. It generalises the fixed direct-mapped 1024-set, 128-bit-line organisation to configurable index width, line width and associativity (1 or 2 ways, LRU replacement). It holds tag, valid, dirty and data storage internally and runs a four-state FSM.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 128, line width in bits; power of two, at least 64
- INDEX_W, 10, set index bits; 2^INDEX_W sets
- WAYS, 2, associativity; legal values 1 or 2
- Derived: OFFSET_W = log2(LINE_W/8); TAG_W = ADDR_W-INDEX_W-OFFSET_W. Defaults give 4 and 18.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cpu_req_addr  in  ADDR_W  request byte address; bits [1:0] ignored
- cpu_req_data  in  32  write data
- cpu_req_rw  in  1  0 = read, 1 = write
- cpu_req_valid  in  1  request valid
- cpu_res_data  out  32  read data
- cpu_res_ready  out  1  one-cycle completion pulse
- mem_req_addr  out  ADDR_W  line address; low OFFSET_W bits are 0
- mem_req_data  out  LINE_W  write-back line
- mem_req_rw  out  1  0 = line read, 1 = line write
- mem_req_valid  out  1  memory request valid
- mem_data  in  LINE_W  line read data
- mem_ready  in  1  memory completes the current request this cycle

## Operation
- **Address split:** tag = addr[ADDR_W-1 -: TAG_W]; index = addr[OFFSET_W +: INDEX_W]; word = addr[OFFSET_W-1:2].
- **Per way and set storage:** valid bit, dirty bit, tag, LINE_W data. When WAYS=2, each set also has one LRU bit naming the least-recently-used way.
- **IDLE:** when cpu_req_valid=1, latch addr, data and rw, then go to COMPARE. cpu_req_* is ignored in all other states.
- **COMPARE, hit** (any way has valid=1 and a matching tag):
  - Read: drive the selected 32-bit word on cpu_res_data.
  - Write: merge the word into the line and set dirty=1.
  - In both cases assert cpu_res_ready, set LRU to the other way, and go to IDLE.
- **COMPARE, miss:**
  - Victim selection: the lowest-numbered invalid way; if none, the LRU way. When WAYS=1 the victim is always way 0.
  - If the victim has valid=1 and dirty=1, go to WRITE_BACK; otherwise go to ALLOCATE.
- **WRITE_BACK:** drive mem_req_valid=1, rw=1, addr={victim tag, index, 0}, data=victim line. On mem_ready, go to ALLOCATE.
- **ALLOCATE:** drive mem_req_valid=1, rw=0, addr={req tag, index, 0}. On mem_ready, write mem_data into the victim way with valid=1, dirty=0 and the new tag, then go to COMPARE. The retry in COMPARE then hits.
- mem_ready is ignored in IDLE and COMPARE.
- **Reset** (rst_n=0 at a clk edge):
  - State goes to IDLE; all valid, dirty and LRU bits are cleared.
  - All outputs become 0.
  - Any in-flight transaction is abandoned and dirty data is discarded.
  - Tag and data arrays need no reset.

## Timing
- Cycle 0 is the IDLE cycle that samples cpu_req_valid=1.
- **Hit:** cpu_res_ready=1 in cycle 1 (the COMPARE cycle). cpu_res_data is valid in that cycle only.
- **Clean miss:** ALLOCATE starts in cycle 2. With mem_ready in cycle k, the fill is written at the end of cycle k and cpu_res_ready=1 in cycle k+1. Minimum is cycle 3.
- **Dirty miss:** WRITE_BACK starts in cycle 2. The ALLOCATE request starts the cycle after the write-back's mem_ready. Minimum response is cycle 4.
- **Memory request hold:** mem_req_* stays stable while mem_req_valid=1 until mem_ready. mem_req_valid drops, or switches to the ALLOCATE request, the cycle after mem_ready.
- cpu_res_ready is high for exactly one cycle per request. cpu_res_data is undefined while cpu_res_ready=0.
- A cpu_req_valid still high in the cycle after cpu_res_ready is accepted as a new request.
- cpu_res_ready is decoded from state plus the tag compare. All other outputs are decoded from state and latched request.
- The write-hit merge, dirty update and LRU update take effect at the end of the COMPARE cycle. A back-to-back read of the same address returns the new data.

## Test plan
All scenarios use the defaults (WAYS=2, INDEX_W=10, LINE_W=128) unless stated. 0x1000, 0x5000 and 0x9000 share index 0x100 with tags 0, 1 and 2.
- **Cold read miss:** after reset, read 0x0000_1004; memory returns a line with word 1 = 0xDEADBEEF and mem_ready in the first ALLOCATE cycle. Required: mem_req addr 0x0000_1000, rw=0; cpu_res_data=0xDEADBEEF with cpu_res_ready in cycle 3.
- **Write hit:** write 0x0000_1008 with 0x12345678. Required: ready in cycle 1 with no mem_req_valid; a following read of 0x1008 returns 0x12345678 in cycle 1.
- **Conflict and LRU:** read 0x1000, then 0x5000, then 0x1000 (hit), then 0x9000. Required: 0x9000 replaces the 0x5000 way; re-reading 0x1000 hits.
- **Dirty eviction:** write 0x1000 = 0xA5A5A5A5, read 0x5000, then read 0x9000. Required: a WRITE_BACK to addr 0x0000_1000, rw=1, with word 0 = 0xA5A5A5A5, followed by ALLOCATE of 0x0000_9000.
- **Memory stall and reset:**
  - Hold mem_ready=0 for 5 cycles during ALLOCATE. Required: mem_req_* stable and cpu_res_ready=0 throughout.
  - Then pulse rst_n=0 for one cycle. Required: all outputs 0 the next cycle; a read of 0x1000 then misses.
- **WAYS=1 build:** read 0x1000, then 0x5000, then 0x1000. Required: three misses and three ALLOCATE requests.
